// File: rtl/mac_share_arb.sv
// Round-robin issue arbiter for a shared fixed-latency MAC datapath.
// Results are collected into a credit-protected in-order FIFO.
module mac_share_arb #(
  parameter int NREQ  = 4,
  parameter int LOGA  = 60,
  parameter int LOGB  = 60,
  parameter int LOGE  = 32,
  parameter int LOGC  = 121,
  parameter int LAT   = 3,
  parameter int DEPTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*LOGA-1:0] req_a,
  input  logic [NREQ*LOGB-1:0] req_b,
  input  logic [NREQ*LOGE-1:0] req_e,
  output logic [LOGA-1:0]      mac_a,
  output logic [LOGB-1:0]      mac_b,
  output logic [LOGE-1:0]      mac_e,
  input  logic [LOGC-1:0]      mac_c,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [LOGC-1:0]      res_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = IDW + LOGC;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P   = PW'(DEPTH - 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  if (DEPTH < LAT + 2) begin : g_depth_check
    $error("mac_share_arb: DEPTH must be at least LAT+2");
  end

  logic [LOGA-1:0] a_arr [NREQ];
  logic [LOGB-1:0] b_arr [NREQ];
  logic [LOGE-1:0] e_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*LOGA +: LOGA];
    assign b_arr[i] = req_b[i*LOGB +: LOGB];
    assign e_arr[i] = req_e[i*LOGE +: LOGE];
  end

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] idx;
  logic           gnt_found;
  logic [CW-1:0]  used;
  logic           issue_en;
  logic           issue;
  logic           pop;
  logic           push;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  // Handshakes: a transfer happens on any cycle where valid & ready are both
  // high. req_ready is a one-hot grant derived from req_valid, ptr and the
  // credit count, so requesters must not make valid depend on ready. On the
  // result side, the head is popped when res_valid & res_ready.
  assign issue_en = (used < DEPTH_C) && !rst;
  assign issue    = gnt_found && issue_en;
  assign pop      = res_valid && res_ready;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      used  <= '0;
      mac_a <= '0;
      mac_b <= '0;
      mac_e <= '0;
    end else begin
      if (issue) begin
        ptr   <= (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
        mac_a <= a_arr[gnt_id];
        mac_b <= b_arr[gnt_id];
        mac_e <= e_arr[gnt_id];
      end
      case ({issue, pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= used - CW'(1);
        default: used <= used;
      endcase
    end
  end

  // Stage 0 lines up with mac_*, stage LAT with the matching mac_c.
  logic [LAT:0]   v;
  logic [IDW-1:0] id_sr [LAT+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k <= LAT; k++) id_sr[k] <= '0;
    end else begin
      v[0]     <= issue;
      id_sr[0] <= gnt_id;
      for (int k = 1; k <= LAT; k++) begin
        v[k]     <= v[k-1];
        id_sr[k] <= id_sr[k-1];
      end
    end
  end

  assign push = v[LAT];

  // Credits bound the occupancy, so push never meets a full FIFO.
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {id_sr[LAT], mac_c};
        wr_ptr      <= (wr_ptr == LAST_P) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign res_valid          = (count != '0);
  assign {res_id, res_data} = mem[rd_ptr];

endmodule
